// File: rtl/mem_store_buffer_if.sv
// Request/response and data-memory-side signals of the posted-write store buffer.
// The master view is the MEM stage side; the slave view is the buffer itself.
interface mem_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              stall;
  logic              load_hit;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_writedata;
  logic              dm_memread;
  logic              dm_memwrite;
  logic [CNT_W-1:0]  count;
  logic              empty;

  modport master (
    output memread, memwrite, address, writedata,
    input  stall, load_hit, load_data,
    input  dm_address, dm_writedata, dm_memread, dm_memwrite,
    input  count, empty
  );

  modport slave (
    input  memread, memwrite, address, writedata,
    output stall, load_hit, load_data,
    output dm_address, dm_writedata, dm_memread, dm_memwrite,
    output count, empty
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-write buffer between EX/MEM and data memory: queues stores, drains them in
// port-idle cycles, forwards buffered data to hitting loads, forces a drain after starvation.
module mem_store_buffer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_DEFER = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam int WA_W  = ADDR_W - 2;

  logic [WA_W-1:0]   waddr_q [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEF_W-1:0]  defer_q, defer_d;

  logic              full;
  logic              is_empty;
  logic              forced;
  logic              load_go;
  logic              push;
  logic              pop;
  logic [WA_W-1:0]   req_wa;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_rd;
  logic              dm_wr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);
  assign forced   = (defer_q == DEF_W'(MAX_DEFER)) && !is_empty;
  assign load_go  = bus.memread && !forced;
  assign req_wa   = bus.address[ADDR_W-1:2];

  // Port arbitration: forced drain, then load, then opportunistic drain.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    if (forced) begin
      dm_addr  = {waddr_q[head_q], 2'b00};
      dm_wdata = wdata_q[head_q];
      dm_wr    = 1'b1;
    end else if (bus.memread) begin
      dm_addr = bus.address;
      dm_rd   = 1'b1;
    end else if (!is_empty) begin
      dm_addr  = {waddr_q[head_q], 2'b00};
      dm_wdata = wdata_q[head_q];
      dm_wr    = 1'b1;
    end
    if (rst) begin
      dm_rd = 1'b0;
      dm_wr = 1'b0;
    end
  end

  assign pop  = dm_wr;
  assign push = bus.memwrite && !full && !rst;

  // Walk oldest to youngest so the last match is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (waddr_q[fwd_idx] == req_wa)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q[fwd_idx];
      end
    end
    if (!load_go) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    defer_d = defer_q;
    if (is_empty || pop) begin
      defer_d = '0;
    end else if (load_go && (defer_q != DEF_W'(MAX_DEFER))) begin
      defer_d = defer_q + DEF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      defer_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      defer_q <= defer_d;
    end
  end

  // Storage needs no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[tail_q] <= req_wa;
      wdata_q[tail_q] <= bus.writedata;
    end
  end

  assign bus.stall        = (bus.memwrite && full) || (bus.memread && forced);
  assign bus.load_hit     = fwd_hit;
  assign bus.load_data    = fwd_data;
  assign bus.dm_address   = dm_addr;
  assign bus.dm_writedata = dm_wdata;
  assign bus.dm_memread   = dm_rd;
  assign bus.dm_memwrite  = dm_wr;
  assign bus.count        = count_q;
  assign bus.empty        = is_empty;
endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: hand-derived directed table, tail-wrap sequence, and
// randomized traffic checked against a queue-based reference model.
module tb_mem_store_buffer;
  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_DEFER = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DEFER(MAX_DEFER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        rst, mr, mw;
    logic [31:0] addr, wd;
    logic        stall, hit;
    logic [31:0] ld;
    logic        dmr, dmw;
    logic [31:0] dma, dmd;
    logic [2:0]  cnt;
  } vec_t;

  ent_t mq[$];
  int   defer_m;
  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic        e_stall, e_hit, e_dmr, e_dmw, m_loadb;
  logic [31:0] e_ld, e_dma, e_dmd;
  int          e_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, mr, mw, input logic [31:0] a, d,
                     input logic st, h, input logic [31:0] ld,
                     input logic dr, dw, input logic [31:0] da, dd, input logic [2:0] c);
    vec_t v;
    v.rst = r; v.mr = mr; v.mw = mw; v.addr = a; v.wd = d;
    v.stall = st; v.hit = h; v.ld = ld; v.dmr = dr; v.dmw = dw;
    v.dma = da; v.dmd = dd; v.cnt = c;
    vq.push_back(v);
  endtask

  // Reference: the buffer is a FIFO queue; the port goes to the head store unless a load
  // wins, and a load may win only while the head has waited fewer than MAX_DEFER loads.
  function automatic void model_eval();
    int sz;
    bit nonempty, frc;
    sz       = mq.size();
    nonempty = (sz > 0);
    frc      = (defer_m == MAX_DEFER) && nonempty;
    m_loadb  = bus.memread && !frc;
    e_stall  = (bus.memwrite && sz == DEPTH) || (bus.memread && frc);
    e_hit = 1'b0; e_ld = '0;
    if (m_loadb) begin
      for (int i = sz - 1; i >= 0; i--) begin
        if (mq[i].wa == bus.address[31:2]) begin
          e_hit = 1'b1;
          e_ld  = mq[i].d;
          break;
        end
      end
    end
    e_dmr = 1'b0; e_dmw = 1'b0; e_dma = '0; e_dmd = '0;
    if (frc || (!bus.memread && nonempty)) begin
      e_dma = {mq[0].wa, 2'b00};
      e_dmd = mq[0].d;
      e_dmw = 1'b1;
    end else if (bus.memread) begin
      e_dma = bus.address;
      e_dmr = 1'b1;
    end
    if (rst) begin
      e_dmr = 1'b0;
      e_dmw = 1'b0;
    end
    e_cnt = sz;
  endfunction

  function automatic void model_commit(input logic mw, input logic mr);
    bit nonempty, was_full;
    ent_t e;
    if (rst) begin
      mq.delete();
      defer_m = 0;
    end else begin
      nonempty = (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      if (e_dmw) void'(mq.pop_front());
      if (mw && !was_full) begin
        e.wa = bus.address[31:2];
        e.d  = bus.writedata;
        mq.push_back(e);
      end
      if (!nonempty || e_dmw) defer_m = 0;
      else if (mr && m_loadb && defer_m < MAX_DEFER) defer_m++;
    end
  endfunction

  task automatic model_check();
    chk("stall", bus.stall, e_stall);
    chk("load_hit", bus.load_hit, e_hit);
    if (e_hit || !m_loadb) chk("load_data", bus.load_data, e_ld);
    chk("dm_memread", bus.dm_memread, e_dmr);
    chk("dm_memwrite", bus.dm_memwrite, e_dmw);
    if (!rst) begin
      chk("dm_address", bus.dm_address, e_dma);
      if (e_dmw || !e_dmr) chk("dm_writedata", bus.dm_writedata, e_dmd);
    end
    chk("count", 64'(bus.count), 64'(e_cnt));
    chk("empty", bus.empty, (e_cnt == 0));
  endtask

  task automatic apply(input logic r, mr, mw, input logic [31:0] a, d);
    rst           = r;
    bus.memread   = mr;
    bus.memwrite  = mw;
    bus.address   = a;
    bus.writedata = d;
    #1;
    model_eval();
  endtask

  task automatic advance();
    logic mw_s, mr_s;
    mw_s = bus.memwrite;
    mr_s = bus.memread;
    @(posedge clk);
    model_commit(mw_s, mr_s);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.memread = 1'b0; bus.memwrite = 1'b0; bus.address = '0; bus.writedata = '0;
    mq.delete();
    defer_m = 0;
    @(negedge clk);
    chk("rst_dm_memwrite", bus.dm_memwrite, 1'b0);
    chk("rst_dm_memread", bus.dm_memread, 1'b0);
    @(negedge clk);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", bus.empty, 1'b1);

    //   r  mr mw addr         wd             st h  ld           dr dw dma          dmd          cnt
    add(0, 0, 1, 32'h40,  32'hAAAA0001, 0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 1, 32'h40,  32'hAAAA0001, 1);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);
    add(0, 0, 1, 32'h80,  32'h11,       0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);
    add(0, 1, 1, 32'h80,  32'h22,       0, 1, 32'h11, 1, 0, 32'h80,  32'h0,        1);
    add(0, 1, 0, 32'h82,  32'h0,        0, 1, 32'h22, 1, 0, 32'h82,  32'h0,        2);
    add(0, 1, 0, 32'h100, 32'h0,        0, 0, 32'h0,  1, 0, 32'h100, 32'h0,        2);
    add(0, 1, 0, 32'h80,  32'h0,        1, 0, 32'h0,  0, 1, 32'h80,  32'h11,       2);
    add(0, 1, 0, 32'h80,  32'h0,        0, 1, 32'h22, 1, 0, 32'h80,  32'h0,        1);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 1, 32'h80,  32'h22,       1);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);
    add(0, 0, 1, 32'h200, 32'hD0000001, 0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);
    add(0, 1, 1, 32'h204, 32'hD0000002, 0, 0, 32'h0,  1, 0, 32'h204, 32'h0,        1);
    add(0, 1, 1, 32'h208, 32'hD0000003, 0, 0, 32'h0,  1, 0, 32'h208, 32'h0,        2);
    add(0, 1, 1, 32'h20C, 32'hD0000004, 0, 0, 32'h0,  1, 0, 32'h20C, 32'h0,        3);
    add(0, 0, 1, 32'h210, 32'hD0000005, 1, 0, 32'h0,  0, 1, 32'h200, 32'hD0000001, 4);
    add(0, 0, 1, 32'h210, 32'hD0000005, 0, 0, 32'h0,  0, 1, 32'h204, 32'hD0000002, 3);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 1, 32'h208, 32'hD0000003, 3);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 1, 32'h20C, 32'hD0000004, 2);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 1, 32'h210, 32'hD0000005, 1);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);
    add(0, 1, 1, 32'h300, 32'hE0000001, 0, 0, 32'h0,  1, 0, 32'h300, 32'h0,        0);
    add(0, 1, 1, 32'h304, 32'hE0000002, 0, 0, 32'h0,  1, 0, 32'h304, 32'h0,        1);
    add(0, 1, 1, 32'h308, 32'hE0000003, 0, 0, 32'h0,  1, 0, 32'h308, 32'h0,        2);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 1, 32'h300, 32'hE0000001, 3);
    add(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        2);
    add(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0);

    rst = 1'b0;
    foreach (vq[k]) begin
      apply(vq[k].rst, vq[k].mr, vq[k].mw, vq[k].addr, vq[k].wd);
      chk($sformatf("t%0d_stall", k), bus.stall, vq[k].stall);
      chk($sformatf("t%0d_hit", k), bus.load_hit, vq[k].hit);
      if (vq[k].hit || !vq[k].mr || vq[k].stall)
        chk($sformatf("t%0d_ldata", k), bus.load_data, vq[k].ld);
      chk($sformatf("t%0d_dmr", k), bus.dm_memread, vq[k].dmr);
      chk($sformatf("t%0d_dmw", k), bus.dm_memwrite, vq[k].dmw);
      if (!vq[k].rst) begin
        chk($sformatf("t%0d_dma", k), bus.dm_address, vq[k].dma);
        if (vq[k].dmw || !vq[k].dmr) chk($sformatf("t%0d_dmd", k), bus.dm_writedata, vq[k].dmd);
      end
      chk($sformatf("t%0d_cnt", k), 64'(bus.count), 64'(vq[k].cnt));
      model_check();
      advance();
    end

    // Alternating push/drain walks the pointers past DEPTH; drains must stay in FIFO order.
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 1'b0, 1'b1, 32'h400 + 32'(8 * k), 32'hF0 + 32'(k));
      chk("wrap_push_count", 64'(bus.count), 64'd0);
      model_check();
      advance();
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("wrap_dmw", bus.dm_memwrite, 1'b1);
      chk("wrap_dma", bus.dm_address, 32'h400 + 32'(8 * k));
      chk("wrap_dmd", bus.dm_writedata, 32'hF0 + 32'(k));
      model_check();
      advance();
    end

    for (int n = 0; n < 3000; n++) begin
      logic r, mr, mw;
      logic [31:0] a;
      r  = ($urandom_range(0, 199) == 0);
      mr = ($urandom_range(0, 9) < 6);
      mw = ($urandom_range(0, 9) < 5);
      a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      apply(r, mr, mw, a, $urandom);
      model_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
